// File: rtl/msi_bus_arbiter_if.sv
// Snooping bus bundle between the private caches and the MSI bus arbiter.
// Per-cache request fields are flat vectors; cache k occupies slice k of each.
interface msi_bus_arbiter_if #(
  parameter int unsigned NUM_CPUS = 2,
  parameter int unsigned ADDR_W   = 1
);
  logic [NUM_CPUS-1:0]        req_i;
  logic [3*NUM_CPUS-1:0]      msg_i;
  logic [ADDR_W*NUM_CPUS-1:0] addr_i;
  logic [NUM_CPUS-1:0]        flush_i;
  logic [NUM_CPUS-1:0]        grant_o;
  logic [2:0]                 bus_msg_o;
  logic [ADDR_W-1:0]          bus_addr_o;
  logic                       data_valid_o;
  logic                       done_o;
  logic                       err_o;

  // Cache side: issues requests and snoop responses, observes the bus.
  modport master (
    output req_i, msg_i, addr_i, flush_i,
    input  grant_o, bus_msg_o, bus_addr_o, data_valid_o, done_o, err_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, msg_i, addr_i, flush_i,
    output grant_o, bus_msg_o, bus_addr_o, data_valid_o, done_o, err_o
  );
endinterface

// File: rtl/msi_bus_arbiter.sv
// MSI snooping bus arbiter: round-robin grant among eligible caches, one-cycle
// snoop broadcast, cache-to-cache flush or fixed-latency memory fill, then a
// one-cycle completion to the owner. All outputs come straight from registers.
module msi_bus_arbiter #(
  parameter int unsigned NUM_CPUS = 2,
  parameter int unsigned ADDR_W   = 1,
  parameter int unsigned MEM_LAT  = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  msi_bus_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  localparam int unsigned CNT_W = (MEM_LAT  > 1) ? $clog2(MEM_LAT)  : 1;

  typedef enum logic [2:0] {
    MSG_IDLE  = 3'd0,
    MSG_RD    = 3'd1,
    MSG_RDX   = 3'd2,
    MSG_UPGR  = 3'd3,
    MSG_FLUSH = 3'd4
  } msg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_WAIT_MEM,
    ST_RESP
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          msg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_CPUS-1:0] grant_q;
  logic [2:0]          bus_msg_q;
  logic                dv_q;
  logic                done_q;
  logic                err_q;

  logic [2:0]          req_msg  [NUM_CPUS];
  logic [ADDR_W-1:0]   req_addr [NUM_CPUS];
  logic [NUM_CPUS-1:0] elig;
  logic [NUM_CPUS-1:0] flush_f;
  logic                found;
  logic [PTR_W-1:0]    pick;
  int unsigned         scan_idx;

  // Only RD, RDX and UPGR are requests the bus can carry.
  function automatic logic is_bus_req(input logic [2:0] m);
    return (m == MSG_RD) || (m == MSG_RDX) || (m == MSG_UPGR);
  endfunction

  function automatic logic [NUM_CPUS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_CPUS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Split the flat request vectors per cache and mark eligible requesters.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CPUS; k++) begin
      req_msg[k]  = bus.msg_i[3*k +: 3];
      req_addr[k] = bus.addr_i[ADDR_W*k +: ADDR_W];
      elig[k]     = bus.req_i[k] && is_bus_req(bus.msg_i[3*k +: 3]);
    end
  end

  // Round-robin pick: first eligible index scanning upward from ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      scan_idx = 32'(ptr_q) + i;
      if (scan_idx >= NUM_CPUS) begin
        scan_idx = scan_idx - NUM_CPUS;
      end
      if (!found && elig[PTR_W'(scan_idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(scan_idx);
      end
    end
  end

  // Snoop responses from caches other than the owner; grant_q is onehot(owner)
  // throughout SNOOP, so it doubles as the owner mask.
  always_comb begin
    flush_f = bus.flush_i & ~grant_q;
  end

  // Transaction FSM; outputs are registered alongside the state so each one is
  // set on entry to the state that shows it and cleared on exit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      msg_q     <= '0;
      addr_q    <= '0;
      grant_q   <= '0;
      bus_msg_q <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dv_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            owner_q   <= pick;
            msg_q     <= req_msg[pick];
            addr_q    <= req_addr[pick];
            grant_q   <= onehot(pick);
            bus_msg_q <= req_msg[pick];
            state_q   <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          bus_msg_q <= '0;
          if (msg_q == MSG_UPGR) begin
            done_q  <= 1'b1;
            state_q <= ST_RESP;
          end else if (flush_f != '0) begin
            if ($countones(flush_f) > 1) begin
              err_q <= 1'b1;
            end
            done_q  <= 1'b1;
            dv_q    <= (msg_q == MSG_RD) || (msg_q == MSG_RDX);
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            dv_q    <= (msg_q == MSG_RD) || (msg_q == MSG_RDX);
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          grant_q <= '0;
          ptr_q   <= (owner_q == PTR_W'(NUM_CPUS - 1)) ? '0 : owner_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_o      = grant_q;
  assign bus.bus_msg_o    = bus_msg_q;
  assign bus.bus_addr_o   = addr_q;
  assign bus.data_valid_o = dv_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter with three caches, 1-bit addresses and a
// four-cycle memory fill. Outputs are sampled 1 time unit after each rising edge.
module tb_msi_bus_arbiter;

  logic clk_i;
  logic rst_i;
  int   tests;
  int   fails;

  msi_bus_arbiter_if #(.NUM_CPUS(3), .ADDR_W(1)) bus ();

  msi_bus_arbiter #(.NUM_CPUS(3), .ADDR_W(1), .MEM_LAT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] req;
    logic [8:0] msg;    // one octal digit per cache
    logic [2:0] addr;
    logic [2:0] flush;
    logic [2:0] grant;
    logic [2:0] bmsg;
    logic       baddr;  // checked only while a grant is expected
    logic       dv;
    logic       done;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [8:0] msg,
                       input logic [2:0] addr, input logic [2:0] flush);
    bus.req_i   = req;
    bus.msg_i   = msg;
    bus.addr_i  = addr;
    bus.flush_i = flush;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"}, 32'(bus.grant_o), 0);
    chk({tag, " bus_msg"}, 32'(bus.bus_msg_o), 0);
    chk({tag, " data_valid"}, 32'(bus.data_valid_o), 0);
    chk({tag, " done"}, 32'(bus.done_o), 0);
    chk({tag, " err"}, 32'(bus.err_o), 0);
  endtask

  // Asynchronous reset assertion mid-cycle; leaves the bench at cycle 0 in IDLE.
  task automatic apply_reset(input string tag);
    drive(3'b000, 9'o000, 3'b000, 3'b000);
    #2 rst_i = 1'b0;
    #1 chk_all_zero(tag);
    tick();
    tick();
    #2 rst_i = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_i = 1'b1;
    drive(3'b000, 9'o000, 3'b000, 3'b000);

    //              req     msg     addr    flush   grant   bmsg  ba    dv    done
    // CPU0 RD addr 1, no flush: memory fill, done at cycle 6.
    vecs[0]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 9'o001, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{3'b000, 9'o000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};
    // CPU1 RDX addr 0, CPU0 flushes in SNOOP: done at cycle 2.
    vecs[8]  = '{3'b010, 9'o020, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 9'o020, 3'b000, 3'b001, 3'b010, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 9'o020, 3'b000, 3'b000, 3'b010, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'b000, 9'o000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};
    // CPU0 UPGR (ptr=2 wraps to CPU0), CPU1 flush ignored: done at cycle 2, no data.
    vecs[12] = '{3'b001, 9'o003, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'b001, 9'o003, 3'b000, 3'b010, 3'b001, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b001, 9'o003, 3'b000, 3'b000, 3'b001, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{3'b000, 9'o000, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};

    tick();
    apply_reset("reset");

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].req, vecs[i].msg, vecs[i].addr, vecs[i].flush);
      chk($sformatf("vec%0d grant", i), 32'(bus.grant_o), 32'(vecs[i].grant));
      chk($sformatf("vec%0d bus_msg", i), 32'(bus.bus_msg_o), 32'(vecs[i].bmsg));
      if (vecs[i].grant != 3'b000) begin
        chk($sformatf("vec%0d bus_addr", i), 32'(bus.bus_addr_o), 32'(vecs[i].baddr));
      end
      chk($sformatf("vec%0d data_valid", i), 32'(bus.data_valid_o), 32'(vecs[i].dv));
      chk($sformatf("vec%0d done", i), 32'(bus.done_o), 32'(vecs[i].done));
      chk($sformatf("vec%0d err", i), 32'(bus.err_o), 0);
      tick();
    end

    // Fairness: CPU0 and CPU1 both hold RD; 7-cycle transactions alternate 0,1,0,1.
    apply_reset("reset2");
    drive(3'b011, 9'o011, 3'b000, 3'b000);
    for (int c = 0; c < 28; c++) begin
      logic [2:0] exp_g;
      int pos;
      pos   = c % 7;
      exp_g = (pos == 0) ? 3'b000 : (((c / 7) % 2 == 0) ? 3'b001 : 3'b010);
      chk($sformatf("fair c%0d grant", c), 32'(bus.grant_o), 32'(exp_g));
      chk($sformatf("fair c%0d done", c), 32'(bus.done_o), (pos == 6) ? 1 : 0);
      tick();
    end

    // FLUSH is not a bus request: never granted, no error.
    drive(3'b001, 9'o004, 3'b000, 3'b000);
    for (int n = 0; n < 20; n++) begin
      chk($sformatf("flushreq n%0d grant", n), 32'(bus.grant_o), 0);
      tick();
    end
    chk("flushreq err", 32'(bus.err_o), 0);

    // The owner's own flush bit is masked: still a memory fill.
    drive(3'b001, 9'o001, 3'b000, 3'b000);
    tick();
    drive(3'b001, 9'o001, 3'b000, 3'b001);
    chk("selfflush snoop grant", 32'(bus.grant_o), 32'(3'b001));
    tick();
    drive(3'b001, 9'o001, 3'b000, 3'b000);
    chk("selfflush c2 done", 32'(bus.done_o), 0);
    chk("selfflush c2 grant", 32'(bus.grant_o), 32'(3'b001));
    repeat (4) tick();
    chk("selfflush c6 done", 32'(bus.done_o), 1);
    chk("selfflush c6 dv", 32'(bus.data_valid_o), 1);
    tick();
    drive(3'b000, 9'o000, 3'b000, 3'b000);
    chk("selfflush c7 grant", 32'(bus.grant_o), 0);

    // Two non-owner flushes: cache-to-cache completion plus sticky error.
    drive(3'b001, 9'o001, 3'b000, 3'b000);
    tick();
    drive(3'b001, 9'o001, 3'b000, 3'b110);
    chk("err snoop err", 32'(bus.err_o), 0);
    tick();
    drive(3'b001, 9'o001, 3'b000, 3'b000);
    chk("err c2 done", 32'(bus.done_o), 1);
    chk("err c2 dv", 32'(bus.data_valid_o), 1);
    chk("err c2 err", 32'(bus.err_o), 1);
    tick();
    drive(3'b000, 9'o000, 3'b000, 3'b000);
    repeat (5) tick();
    chk("err sticky", 32'(bus.err_o), 1);

    // Reset during WAIT_MEM aborts without done; CPU1 then wins from ptr=0.
    drive(3'b001, 9'o001, 3'b001, 3'b000);
    repeat (3) tick();
    chk("abort c3 grant", 32'(bus.grant_o), 32'(3'b001));
    #2 rst_i = 1'b0;
    #1 chk_all_zero("abort");
    drive(3'b000, 9'o000, 3'b000, 3'b000);
    tick();
    chk("abort held done", 32'(bus.done_o), 0);
    tick();
    #2 rst_i = 1'b1;
    tick();
    drive(3'b010, 9'o010, 3'b010, 3'b000);
    chk("post c0 grant", 32'(bus.grant_o), 0);
    tick();
    chk("post c1 grant", 32'(bus.grant_o), 32'(3'b010));
    chk("post c1 bus_msg", 32'(bus.bus_msg_o), 1);
    chk("post c1 bus_addr", 32'(bus.bus_addr_o), 1);
    for (int c = 2; c < 6; c++) begin
      tick();
      chk($sformatf("post c%0d done", c), 32'(bus.done_o), 0);
    end
    tick();
    chk("post c6 done", 32'(bus.done_o), 1);
    chk("post c6 dv", 32'(bus.data_valid_o), 1);
    chk("post c6 grant", 32'(bus.grant_o), 32'(3'b010));
    chk("post c6 err", 32'(bus.err_o), 0);
    tick();
    drive(3'b000, 9'o000, 3'b000, 3'b000);
    chk("post c7 grant", 32'(bus.grant_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msi_bus_arbiter.md
Name: msi_bus_arbiter

Overview:
- Sequences the shared MSI snooping bus between NUM_CPUS private caches.
- Grants the bus round-robin to one requesting cache at a time.
- Broadcasts the winner's message and address to all snoopers for one cycle.
- Collects the flush response, falls back to a fixed-latency memory fill if no cache flushes, and signals transaction completion to the owner.

Parameters:
- NUM_CPUS, 2, number of cache requesters (>=2).
- ADDR_W, 1, line address width.
- MEM_LAT, 4, memory fill latency in cycles when no cache flushes (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  NUM_CPUS  per-cache bus request; held until done_o.
- msg_i  in  3*NUM_CPUS  per-cache requested message; cache k uses bits [3k+2:3k]. 0 IDLE, 1 RD, 2 RDX, 3 UPGR, 4 FLUSH.
- addr_i  in  ADDR_W*NUM_CPUS  per-cache line address.
- flush_i  in  NUM_CPUS  per-cache flush response to the snooped message.
- grant_o  out  NUM_CPUS  one-hot bus owner; all-zero when idle.
- bus_msg_o  out  3  broadcast message; 0 except in the SNOOP state.
- bus_addr_o  out  ADDR_W  broadcast address; valid while any grant_o bit is set.
- data_valid_o  out  1  one-cycle pulse: fill data available to the owner (RD/RDX only).
- done_o  out  1  one-cycle pulse: owner's transaction complete.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset, asynchronous: state=IDLE, ptr=0, cnt=0, owner/msg/addr registers=0, err_o=0.
  - All outputs read 0 immediately on assertion.
  - Reset mid-transaction aborts the transaction; no done_o is issued.
- All outputs are decoded from registered state (Moore). There is no combinational path from any input to any output.
- Eligibility: cache k is eligible iff req_i[k]=1 and msg_i[k] is RD, RDX or UPGR.
  - A request with IDLE, FLUSH or codes 5-7 is never granted and sets no error.
- FSM states: IDLE, SNOOP, WAIT_MEM, RESP.
  - IDLE:
    - If any cache is eligible, pick the first eligible index scanning ptr, ptr+1, ..., wrapping mod NUM_CPUS.
    - Latch owner, msg_i[owner] and addr_i[owner]; go to SNOOP.
    - Otherwise stay in IDLE.
  - SNOOP, exactly 1 cycle:
    - grant_o=onehot(owner), bus_msg_o=latched msg, bus_addr_o=latched addr.
    - Sample f = flush_i with the owner's bit masked off.
    - If msg=UPGR, go to RESP; f is ignored.
    - Else if f!=0, go to RESP (cache-to-cache transfer).
    - Else load cnt=MEM_LAT-1 and go to WAIT_MEM.
    - If popcount(f)>1, set err_o and proceed as for the flush case.
  - WAIT_MEM:
    - grant_o is held; bus_msg_o=0.
    - If cnt==0, go to RESP; else cnt-=1.
    - This state lasts exactly MEM_LAT cycles.
    - flush_i is ignored here.
  - RESP, 1 cycle:
    - grant_o is held; done_o=1.
    - data_valid_o=1 iff msg is RD or RDX.
    - ptr <= (owner+1) mod NUM_CPUS, then go to IDLE.
- Owner rule:
  - The owner must deassert req_i, or change to a new request, in the cycle after done_o.
  - A still-asserted req_i is re-arbitrated normally in IDLE under the rotated ptr.
- Latency, from the IDLE cycle that sees the request (cycle 0):
  - SNOOP at cycle 1.
  - RESP at cycle 2 for UPGR or a flush.
  - RESP at cycle MEM_LAT+2 for a memory fill.
- Simultaneous requests: round-robin guarantees each eligible requester a grant within NUM_CPUS transactions.
- The one-cycle IDLE gap between transactions is mandatory.
- err_o clears only on reset.

Test Plan:
- Single RD, no flush, MEM_LAT=4: req_i=01, msg=RD, addr=1 at cycle 0.
  - Expect grant_o=01 and bus_msg_o=1, bus_addr_o=1 at cycle 1.
  - Expect data_valid_o=done_o=1 at cycle 6.
  - Expect grant_o=00 at cycle 7.
- RDX with flush: CPU1 issues RDX addr 0; CPU0 asserts flush_i=01 in SNOOP.
  - Expect done_o and data_valid_o at cycle 2, with no WAIT_MEM cycles.
- UPGR: CPU0 issues UPGR.
  - Expect bus_msg_o=3 for 1 cycle, done_o=1 and data_valid_o=0 at cycle 2.
  - A flush_i asserted during SNOOP is ignored.
- Fairness: req_i=11 held continuously, both RD, ptr=0 after reset.
  - Expect grants in the order CPU0, CPU1, CPU0, CPU1 with a 1-cycle IDLE gap between each.
- Illegal and error cases:
  - msg=FLUSH with req_i=01 is never granted (grant_o stays 00 for 20 cycles).
  - Two non-owner flushes in SNOOP with NUM_CPUS=3 set err_o=1, and err_o stays set until reset.
- Reset mid-WAIT_MEM: assert rst_i=0 asynchronously.
  - Expect grant_o=0, done_o=0, data_valid_o=0 immediately.
  - After release, a new RD from CPU1 wins first (ptr=0, CPU0 idle) and completes normally.
